serial_compare_unit: RTL

Multi-cycle 8-bit magnitude comparator serving the ALU's compare operation. It accepts an operand pair through a valid/ready request handshake and scans the operands bit-serially, MSB first. It returns one-hot greater/equal/less flags through a valid/ready result handshake. It is the responder to the ALU sequencer, which acts as initiator, and it complements the existing combinational greater-than check with signed support and early termination.

---
 rtl/serial_cmp_pkg.sv | 45 ++++
 rtl/serial_compare_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, one-hot result
// ordered {gt, eq, lt}, and the per-bit decision step used while scanning MSB first.
package serial_cmp_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_res_t;

   typedef struct packed {
      logic differ;
      logic gt;
   } bit_step_t;

   // In two's complement the sign bit carries negative weight, so a set MSB means smaller.
   function automatic bit_step_t cmp_bit_step(
      input logic a_bit,
      input logic b_bit,
      input logic is_msb,
      input logic signed_mode
   );
      bit_step_t s;
      s.differ = a_bit ^ b_bit;
      s.gt     = (is_msb && signed_mode) ? ~a_bit : a_bit;
      return s;
   endfunction

   function automatic cmp_res_t res_from_gt(input logic gt_bit);
      cmp_res_t r;
      r.gt = gt_bit;
      r.eq = 1'b0;
      r.lt = ~gt_bit;
      return r;
   endfunction

endpackage

// File: rtl/serial_compare_unit.sv
// Bit-serial MSB-first magnitude compare with valid/ready request and result handshakes.
// SERIAL_CMP_EARLY_EXIT_EN ends the scan at the first differing bit; otherwise it always runs WIDTH cycles.
module serial_compare_unit
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [CNT_W-1:0] cycles
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             smode_q;
   logic [IDX_W-1:0] idx;
   logic             found_q;
   logic             found_gt_q;
   cmp_res_t         res_q;
   cmp_res_t         res_next;
   logic [CNT_W-1:0] cycles_q;
   logic [CNT_W-1:0] cycles_next;
   logic             accept;
   logic             decide;
   bit_step_t        step;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   logic [CNT_W-1:0] cnt;
`endif

   always_comb begin
      step   = cmp_bit_step(a_q[idx], b_q[idx], idx == MSB_IDX, smode_q);
      accept = (state == IDLE) && req_valid;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      decide      = (state == SCAN) && (step.differ || (idx == '0));
      cycles_next = cnt + CNT_W'(1);
`else
      decide      = (state == SCAN) && (idx == '0);
      cycles_next = CNT_W'(WIDTH);
`endif
      // The first (most significant) difference wins; later bits never override it.
      res_next = '0;
      if (found_q) begin
         res_next = res_from_gt(found_gt_q);
      end else if (step.differ) begin
         res_next = res_from_gt(step.gt);
      end else begin
         res_next.eq = 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = SCAN;
         SCAN:    if (decide) state_next = DONE;
         DONE:    if (res_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         smode_q    <= 1'b0;
         idx        <= '0;
         found_q    <= 1'b0;
         found_gt_q <= 1'b0;
         res_q      <= '0;
         cycles_q   <= '0;
      end else if (accept) begin
         a_q        <= a;
         b_q        <= b;
         smode_q    <= signed_mode;
         idx        <= MSB_IDX;
         found_q    <= 1'b0;
         found_gt_q <= 1'b0;
      end else if (state == SCAN) begin
         if (decide) begin
            res_q    <= res_next;
            cycles_q <= cycles_next;
         end else begin
            idx <= idx - IDX_W'(1);
            if (step.differ && !found_q) begin
               found_q    <= 1'b1;
               found_gt_q <= step.gt;
            end
         end
      end
   end

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= '0;
      end else if ((state == SCAN) && !decide) begin
         cnt <= cnt + CNT_W'(1);
      end
   end
`endif

   assign req_ready = (state == IDLE);
   assign res_valid = (state == DONE);
   assign gt        = res_q.gt;
   assign eq        = res_q.eq;
   assign lt        = res_q.lt;
   assign cycles    = cycles_q;

endmodule
